// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
//   rf_state_t     : clear-sequencer states (idle / sweeping entries to zero)
//   RF_*_DEF       : default entry width, address width and read-port count
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W_DEF = 16;
  localparam int RF_ADDR_W_DEF = 4;
  localparam int RF_NUM_RD_DEF = 2;

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between the writeback/operand-fetch logic and the register file.
//   write_en0/1, write_addr0/1, data_in0/1 : two write ports (port 1 wins on clash)
//   read_addr / read_port                  : NUM_RD packed read addresses / data
//   clear_req / busy                       : start and progress of the hardware clear
//   wr_conflict                            : one-cycle pulse after a same-address double write
// master drives writes, read addresses and clear_req; slave is the register file.
interface register_file_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W_DEF,
  parameter int ADDR_W = RF_ADDR_W_DEF,
  parameter int NUM_RD = RF_NUM_RD_DEF
);
  logic                     write_en0;
  logic [ADDR_W-1:0]        write_addr0;
  logic [DATA_W-1:0]        data_in0;
  logic                     write_en1;
  logic [ADDR_W-1:0]        write_addr1;
  logic [DATA_W-1:0]        data_in1;
  logic [NUM_RD*ADDR_W-1:0] read_addr;
  logic [NUM_RD*DATA_W-1:0] read_port;
  logic                     clear_req;
  logic                     busy;
  logic                     wr_conflict;

  modport master (
    output write_en0, write_addr0, data_in0,
    output write_en1, write_addr1, data_in1,
    output read_addr, clear_req,
    input  read_port, busy, wr_conflict
  );

  modport slave (
    input  write_en0, write_addr0, data_in0,
    input  write_en1, write_addr1, data_in1,
    input  read_addr, clear_req,
    output read_port, busy, wr_conflict
  );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: on clear_req in IDLE, sweeps every entry to zero, one per cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   clear_req  : start request, only honoured in IDLE
//   busy       : high for exactly 2**ADDR_W cycles while sweeping
//   clr_en     : zero entry clr_addr at the next edge
//   clr_addr   : entry being zeroed (the sweep counter)
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_IDLE: begin
        if (clear_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        // Counter wraps to 0 on the same edge the sweep finishes.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  assign busy     = (state_q == RF_CLEAR);
  assign clr_en   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports, NUM_RD read ports, optional
// registered reads with write-first bypass, optional hardwired-zero entry 0,
// and a hardware clear sequencer.
//   clk, rst : clock, asynchronous active-high reset (clears every entry)
//   bus      : register_file_mp_if slave (write ports, read ports, clear, status)
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W_DEF,
  parameter int ADDR_W   = RF_ADDR_W_DEF,
  parameter int NUM_RD   = RF_NUM_RD_DEF,
  parameter int RD_REG   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  register_file_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_conflict_q, wr_conflict_d;
  logic              busy, clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              drop0, drop1;
  logic [DATA_W-1:0] rd_data [NUM_RD];

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .clear_req (bus.clear_req),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr)
  );

  // Entry 0 is read-only when hardwired to zero.
  assign drop0 = (ZERO_REG != 0) && (bus.write_addr0 == '0);
  assign drop1 = (ZERO_REG != 0) && (bus.write_addr1 == '0);

  // Next array contents: the clear sweep owns the array while busy; otherwise
  // port 1 is applied after port 0 so it wins an address clash.
  always_comb begin
    mem_d = mem_q;
    if (clr_en) begin
      mem_d[clr_addr] = '0;
    end else begin
      if (bus.write_en0 && !drop0) mem_d[bus.write_addr0] = bus.data_in0;
      if (bus.write_en1 && !drop1) mem_d[bus.write_addr1] = bus.data_in1;
    end
  end

  // A dropped entry-0 clash is still a clash, so the flag ignores drop0/drop1.
  assign wr_conflict_d = !busy && bus.write_en0 && bus.write_en1 &&
                         (bus.write_addr0 == bus.write_addr1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q         <= '{default: '0};
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              ra_zero;
      assign ra      = bus.read_addr[gi*ADDR_W +: ADDR_W];
      assign ra_zero = (ZERO_REG != 0) && (ra == '0);

      if (RD_REG != 0) begin : g_reg
        logic [DATA_W-1:0] rd_q, rd_d;
        // Reading mem_d gives write-first bypass; during a clear the sweep's
        // own zeroing is not forwarded, so current contents are captured.
        always_comb begin
          rd_d = busy ? mem_q[ra] : mem_d[ra];
          if (ra_zero) rd_d = '0;
        end
        always_ff @(posedge clk or posedge rst) begin
          if (rst) rd_q <= '0;
          else     rd_q <= rd_d;
        end
        assign rd_data[gi] = rd_q;
      end else begin : g_comb
        assign rd_data[gi] = ra_zero ? '0 : mem_q[ra];
      end
    end
  endgenerate

  always_comb begin
    bus.read_port = '0;
    for (int k = 0; k < NUM_RD; k++) bus.read_port[k*DATA_W +: DATA_W] = rd_data[k];
  end

  assign bus.busy        = busy;
  assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default registered-read instance (a),
// a hardwired-zero instance (z) and a combinational-read instance (c).
module tb_register_file_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  register_file_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) if_a ();
  register_file_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) if_z ();
  register_file_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) if_c ();

  register_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .RD_REG(1), .ZERO_REG(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  register_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .RD_REG(1), .ZERO_REG(1))
    dut_z (.clk(clk), .rst(rst), .bus(if_z.slave));
  register_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .RD_REG(0), .ZERO_REG(0))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    if_a.write_en0 = 0; if_a.write_en1 = 0; if_a.clear_req = 0;
  endtask

  int n;

  initial begin
    if_a.write_en0 = 0; if_a.write_addr0 = 0; if_a.data_in0 = 0;
    if_a.write_en1 = 0; if_a.write_addr1 = 0; if_a.data_in1 = 0;
    if_a.read_addr = 0; if_a.clear_req = 0;
    if_z.write_en0 = 0; if_z.write_addr0 = 0; if_z.data_in0 = 0;
    if_z.write_en1 = 0; if_z.write_addr1 = 0; if_z.data_in1 = 0;
    if_z.read_addr = 0; if_z.clear_req = 0;
    if_c.write_en0 = 0; if_c.write_addr0 = 0; if_c.data_in0 = 0;
    if_c.write_en1 = 0; if_c.write_addr1 = 0; if_c.data_in1 = 0;
    if_c.read_addr = 0; if_c.clear_req = 0;

    tick(); tick();
    rst = 0;
    tick();

    // Reset state
    chk("reset_read_port", {16'h0, if_a.read_port}, 32'h0);
    chk("reset_busy", {31'h0, if_a.busy}, 32'h0);
    chk("reset_wr_conflict", {31'h0, if_a.wr_conflict}, 32'h0);

    // 1: two independent writes in the same cycle, read back next cycle
    if_a.write_en0 = 1; if_a.write_addr0 = 4; if_a.data_in0 = 16'h5560;
    if_a.write_en1 = 1; if_a.write_addr1 = 9; if_a.data_in1 = 16'h7380;
    tick();
    chk("t1_no_conflict", {31'h0, if_a.wr_conflict}, 32'h0);
    idle_a();
    if_a.read_addr = {4'd9, 4'd4};
    tick();
    chk("t1_rd0_addr4", {16'h0, if_a.read_port[15:0]}, 32'h5560);
    chk("t1_rd1_addr9", {16'h0, if_a.read_port[31:16]}, 32'h7380);

    // 2: clash on address 12, port 1 wins, flag pulses for one cycle
    if_a.write_en0 = 1; if_a.write_addr0 = 12; if_a.data_in0 = 16'h1111;
    if_a.write_en1 = 1; if_a.write_addr1 = 12; if_a.data_in1 = 16'h2222;
    tick();
    chk("t2_conflict_set", {31'h0, if_a.wr_conflict}, 32'h1);
    idle_a();
    if_a.read_addr = {4'd4, 4'd12};
    tick();
    chk("t2_entry12", {16'h0, if_a.read_port[15:0]}, 32'h2222);
    chk("t2_conflict_clear", {31'h0, if_a.wr_conflict}, 32'h0);

    // 3: write-first bypass on read port 1
    if_a.read_addr = {4'd3, 4'd12};
    if_a.write_en0 = 1; if_a.write_addr0 = 3; if_a.data_in0 = 16'hBEEF;
    tick();
    chk("t3_bypass_rd1", {16'h0, if_a.read_port[31:16]}, 32'hBEEF);
    chk("t3_rd0_unchanged", {16'h0, if_a.read_port[15:0]}, 32'h2222);
    idle_a();

    // 4: fill with A5A5, then hardware clear
    for (int i = 0; i < 8; i++) begin
      if_a.write_en0 = 1; if_a.write_addr0 = 4'(i);     if_a.data_in0 = 16'hA5A5;
      if_a.write_en1 = 1; if_a.write_addr1 = 4'(i + 8); if_a.data_in1 = 16'hA5A5;
      tick();
    end
    idle_a();
    if_a.read_addr = {4'd15, 4'd5};
    tick();
    chk("t4_fill_addr5", {16'h0, if_a.read_port[15:0]}, 32'hA5A5);
    chk("t4_fill_addr15", {16'h0, if_a.read_port[31:16]}, 32'hA5A5);
    if_a.clear_req = 1;
    tick();
    if_a.clear_req = 0;
    n = 0;
    while (if_a.busy && n < 40) begin
      n++;
      // Writes during the sweep must be ignored (address 0 already swept here).
      if (n == 3) begin
        if_a.write_en0 = 1; if_a.write_addr0 = 5; if_a.data_in0 = 16'h7777;
        if_a.write_en1 = 1; if_a.write_addr1 = 0; if_a.data_in1 = 16'h7777;
      end else begin
        if_a.write_en0 = 0; if_a.write_en1 = 0;
      end
      if_a.clear_req = (n == 8);
      tick();
      if (n == 3) chk("t4_no_flag_while_busy", {31'h0, if_a.wr_conflict}, 32'h0);
    end
    idle_a();
    chk("t4_busy_cycles", n, 32'd16);
    tick();
    chk("t4_no_restart", {31'h0, if_a.busy}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if_a.read_addr = {4'(i + 8), 4'(i)};
      tick();
      chk($sformatf("t4_clr_addr%0d", i), {16'h0, if_a.read_port[15:0]}, 32'h0);
      chk($sformatf("t4_clr_addr%0d", i + 8), {16'h0, if_a.read_port[31:16]}, 32'h0);
    end

    // 5: hardwired-zero entry 0
    if_z.write_en0 = 1; if_z.write_addr0 = 0; if_z.data_in0 = 16'h1234;
    tick();
    if_z.write_addr0 = 1;
    if_z.read_addr = {4'd1, 4'd0};
    tick();
    if_z.write_en0 = 0;
    tick();
    chk("t5_zero_rd_addr0", {16'h0, if_z.read_port[15:0]}, 32'h0);
    chk("t5_zero_rd_addr1", {16'h0, if_z.read_port[31:16]}, 32'h1234);
    if_z.write_en0 = 1; if_z.write_addr0 = 0; if_z.data_in0 = 16'h5555;
    if_z.write_en1 = 1; if_z.write_addr1 = 0; if_z.data_in1 = 16'h6666;
    tick();
    chk("t5_zero_clash_flag", {31'h0, if_z.wr_conflict}, 32'h1);
    chk("t5_zero_clash_rd0", {16'h0, if_z.read_port[15:0]}, 32'h0);
    if_z.write_en0 = 0; if_z.write_en1 = 0;

    // 7: combinational read, new value visible only after the edge
    if_c.write_en0 = 1; if_c.write_addr0 = 7; if_c.data_in0 = 16'h0011;
    tick();
    if_c.read_addr = {4'd0, 4'd7};
    if_c.data_in0 = 16'h00FF;
    #1;
    chk("t7_comb_before_edge", {16'h0, if_c.read_port[15:0]}, 32'h0011);
    tick();
    if_c.write_en0 = 0;
    chk("t7_comb_after_edge", {16'h0, if_c.read_port[15:0]}, 32'h00FF);

    // 6: reset aborts a clear in progress
    if_a.write_en0 = 1; if_a.write_addr0 = 14; if_a.data_in0 = 16'h4242;
    tick();
    idle_a();
    if_a.read_addr = {4'd14, 4'd14};
    if_a.clear_req = 1;
    tick();
    if_a.clear_req = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_busy_mid_clear", {31'h0, if_a.busy}, 32'h1);
    chk("t6_rd_mid_clear", {16'h0, if_a.read_port[15:0]}, 32'h4242);
    #2;
    rst = 1;
    #1;
    chk("t6_busy_after_rst", {31'h0, if_a.busy}, 32'h0);
    chk("t6_rd_after_rst", {16'h0, if_a.read_port}, 32'h0);
    chk("t6_flag_after_rst", {31'h0, if_a.wr_conflict}, 32'h0);
    tick();
    rst = 0;
    tick();
    chk("t6_entry14_zero", {16'h0, if_a.read_port[15:0]}, 32'h0);
    chk("t6_idle_after_rst", {31'h0, if_a.busy}, 32'h0);
    if_a.read_addr = {4'd12, 4'd9};
    tick();
    chk("t6_entry9_zero", {16'h0, if_a.read_port[15:0]}, 32'h0);
    chk("t6_entry12_zero", {16'h0, if_a.read_port[31:16]}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
